// File: rtl/wall_collision_checker.sv
// rtl/wall_collision_checker.sv - maze wall collision query engine with tunnel wrap
// Answers "may a TILE_PX x TILE_PX sprite move step pixels in dir?" against a
// fixed maze mask. One query in flight, valid/ready on request and response.
module wall_collision_checker #(
   parameter int TILE_PX = 16,
   parameter int POS_W   = 11,
   parameter int WRAP_LO = 64,
   parameter int WRAP_HI = 528
) (
   input  logic             clk_i,
   input  logic             resetN_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [POS_W-1:0] req_x_i,
   input  logic [POS_W-1:0] req_y_i,
   input  logic [1:0]       req_dir_i,
   input  logic [3:0]       req_step_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic             resp_allowed_o,
   output logic [POS_W-1:0] resp_x_o,
   output logic [POS_W-1:0] resp_y_o,
   output logic [15:0]      blocked_cnt_o
);

   // Signed working width: one extra bit so moves past zero go negative.
   localparam int CW        = POS_W + 1;
   localparam int TILE_SH   = $clog2(TILE_PX);
   localparam int MAZE_COLS = 40;
   localparam int MAZE_ROWS = 30;
   localparam int START_X   = 5;
   localparam int END_X     = 32;
   localparam int START_Y   = 1;
   localparam int END_Y     = 28;

   localparam logic [CW-1:0]        COL_LO      = CW'(START_X);
   localparam logic [CW-1:0]        COL_HI      = CW'(END_X);
   localparam logic [CW-1:0]        ROW_LO      = CW'(START_Y);
   localparam logic [CW-1:0]        ROW_HI      = CW'(END_Y);
   localparam logic signed [CW-1:0] EDGE        = CW'(TILE_PX - 1);
   localparam logic signed [CW-1:0] WRAP_LO_C   = CW'(WRAP_LO);
   localparam logic signed [CW-1:0] WRAP_HI_C   = CW'(WRAP_HI);
   localparam logic signed [CW-1:0] WRAP_SPAN_C = CW'(WRAP_HI - WRAP_LO);

   localparam logic [1:0] DIR_RIGHT = 2'd0;
   localparam logic [1:0] DIR_LEFT  = 2'd1;
   localparam logic [1:0] DIR_UP    = 2'd2;
   localparam logic [1:0] DIR_DOWN  = 2'd3;

   // Static maze: one word per tile row, bit n = tile column n, 1 = wall.
   // Row 13 is the open tunnel row; columns 5 and 32 form the side walls.
   localparam logic [MAZE_COLS-1:0] WALL_MASK [MAZE_ROWS] = '{
      40'hFF_FFFF_FFFF, 40'h01_0000_0020, 40'h01_0000_70A0, 40'h01_3C03_C3E0,
      40'h01_3C03_C3E0, 40'h01_0000_0020, 40'h01_0F18_1E20, 40'h01_0F18_1E20,
      40'h01_0018_0020, 40'h01_F0FF_0FE0, 40'h01_F000_0FE0, 40'h01_F0FF_0FE0,
      40'h01_F000_0FE0, 40'h00_0000_0000, 40'h01_F000_0FE0, 40'h01_F0FF_0FE0,
      40'h01_0018_0020, 40'h01_3C18_3C20, 40'h01_0400_2020, 40'h01_C4FF_23E0,
      40'h01_0018_0020, 40'h01_3F18_FC20, 40'h01_0000_0020, 40'h01_3C3C_3C20,
      40'h01_0000_0020, 40'h01_E7E7_E7E0, 40'h01_0000_0020, 40'h01_0000_0020,
      40'h01_FFFF_FFE0, 40'hFF_FFFF_FFFF
   };

   typedef enum logic [2:0] {IDLE, CALC, CHK0, CHK1, RESP} state_t;

   state_t                 state_q;
   logic                   req_ready_q;
   logic [POS_W-1:0]       x_q, y_q;
   logic [1:0]             dir_q;
   logic [3:0]             step_q;
   logic signed [CW-1:0]   nx_q, ny_q, ax_q, ay_q, bx_q, by_q;
   logic signed [CW-1:0]   nx_d, ny_d, ax_d, ay_d, bx_d, by_d;
   logic                   wall_a_q;
   logic                   resp_valid_q, resp_allowed_q;
   logic [POS_W-1:0]       resp_x_q, resp_y_q;
   logic [POS_W-1:0]       resp_x_d, resp_y_d;
   logic [15:0]            blocked_cnt_q;
   logic signed [CW-1:0]   lk_x, lk_y;
   logic                   lk_wall;
   logic                   allowed_d;

   // Tile classification: off-maze rows are walls, off-maze columns are tunnel.
   function automatic logic lookup(input logic signed [CW-1:0] px,
                                   input logic signed [CW-1:0] py);
      logic [CW-1:0] col;
      logic [CW-1:0] row;
      col = $unsigned(px) >> TILE_SH;
      row = $unsigned(py) >> TILE_SH;
      if (py[CW-1] || row < ROW_LO || row > ROW_HI) begin
         return 1'b1;
      end else if (px[CW-1] || col < COL_LO || col > COL_HI) begin
         return 1'b0;
      end else begin
         return WALL_MASK[row[4:0]][col[5:0]];
      end
   endfunction

   // Next position and the two leading-edge corners for the captured move.
   always_comb begin
      logic signed [CW-1:0] xs, ys, st;
      xs   = $signed({1'b0, x_q});
      ys   = $signed({1'b0, y_q});
      st   = $signed({{(CW-4){1'b0}}, step_q});
      nx_d = xs;
      ny_d = ys;
      ax_d = xs;
      ay_d = ys;
      bx_d = xs;
      by_d = ys;
      case (dir_q)
         DIR_RIGHT: begin
            nx_d = xs + st;
            ax_d = nx_d + EDGE;  ay_d = ys;
            bx_d = nx_d + EDGE;  by_d = ys + EDGE;
         end
         DIR_LEFT: begin
            nx_d = xs - st;
            ax_d = nx_d;         ay_d = ys;
            bx_d = nx_d;         by_d = ys + EDGE;
         end
         DIR_UP: begin
            ny_d = ys - st;
            ax_d = xs;           ay_d = ny_d;
            bx_d = xs + EDGE;    by_d = ny_d;
         end
         default: begin
            ny_d = ys + st;
            ax_d = xs;           ay_d = ny_d + EDGE;
            bx_d = xs + EDGE;    by_d = ny_d + EDGE;
         end
      endcase
   end

   // Single mask port shared by both corner checks.
   always_comb begin
      lk_x    = (state_q == CHK1) ? bx_q : ax_q;
      lk_y    = (state_q == CHK1) ? by_q : ay_q;
      lk_wall = lookup(lk_x, lk_y);
   end

   // Resulting position with horizontal tunnel wrap.
   always_comb begin
      allowed_d = !wall_a_q && !lk_wall;
      resp_x_d  = POS_W'(nx_q);
      resp_y_d  = POS_W'(ny_q);
      if (dir_q == DIR_RIGHT && nx_q > WRAP_HI_C) begin
         resp_x_d = POS_W'(nx_q - WRAP_SPAN_C);
      end else if (dir_q == DIR_LEFT && nx_q < WRAP_LO_C) begin
         resp_x_d = POS_W'(nx_q + WRAP_SPAN_C);
      end
   end

   // Query sequencer: capture, compute, two lookups, then hold the response.
   always_ff @(posedge clk_i or negedge resetN_i) begin
      if (!resetN_i) begin
         state_q        <= IDLE;
         req_ready_q    <= 1'b1;
         x_q            <= '0;
         y_q            <= '0;
         dir_q          <= '0;
         step_q         <= '0;
         nx_q           <= '0;
         ny_q           <= '0;
         ax_q           <= '0;
         ay_q           <= '0;
         bx_q           <= '0;
         by_q           <= '0;
         wall_a_q       <= 1'b0;
         resp_valid_q   <= 1'b0;
         resp_allowed_q <= 1'b0;
         resp_x_q       <= '0;
         resp_y_q       <= '0;
         blocked_cnt_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  x_q         <= req_x_i;
                  y_q         <= req_y_i;
                  dir_q       <= req_dir_i;
                  step_q      <= req_step_i;
                  req_ready_q <= 1'b0;
                  state_q     <= CALC;
               end
            end
            CALC: begin
               nx_q    <= nx_d;
               ny_q    <= ny_d;
               ax_q    <= ax_d;
               ay_q    <= ay_d;
               bx_q    <= bx_d;
               by_q    <= by_d;
               state_q <= CHK0;
            end
            CHK0: begin
               wall_a_q <= lk_wall;
               state_q  <= CHK1;
            end
            CHK1: begin
               resp_allowed_q <= allowed_d;
               resp_x_q       <= allowed_d ? resp_x_d : x_q;
               resp_y_q       <= allowed_d ? resp_y_d : y_q;
               if (!allowed_d && blocked_cnt_q != 16'hFFFF) begin
                  blocked_cnt_q <= blocked_cnt_q + 16'd1;
               end
               state_q <= RESP;
            end
            RESP: begin
               if (!resp_valid_q) begin
                  resp_valid_q <= 1'b1;
               end else if (resp_ready_i) begin
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready_o    = req_ready_q;
   assign resp_valid_o   = resp_valid_q;
   assign resp_allowed_o = resp_allowed_q;
   assign resp_x_o       = resp_x_q;
   assign resp_y_o       = resp_y_q;
   assign blocked_cnt_o  = blocked_cnt_q;

endmodule

// File: tb/tb_wall_collision_checker.sv
// tb/tb_wall_collision_checker.sv - scoreboard bench for wall_collision_checker
module tb_wall_collision_checker;

   logic        clk = 1'b0;
   logic        resetN;
   logic        req_valid;
   logic        req_ready;
   logic [10:0] req_x, req_y;
   logic [1:0]  req_dir;
   logic [3:0]  req_step;
   logic        resp_valid;
   logic        resp_ready;
   logic        resp_allowed;
   logic [10:0] resp_x, resp_y;
   logic [15:0] blocked_cnt;

   typedef struct {
      logic        allowed;
      logic [10:0] x;
      logic [10:0] y;
      logic [15:0] cnt;
      int          t_acc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        cur;
   bit          in_resp = 0;
   int          cyc = 0;
   int          n_vec = 0;
   int          n_fail = 0;
   logic [15:0] exp_cnt = 16'd0;

   localparam logic [1:0] R = 2'd0, L = 2'd1, U = 2'd2, D = 2'd3;

   wall_collision_checker dut (
      .clk_i          (clk),
      .resetN_i       (resetN),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_x_i        (req_x),
      .req_y_i        (req_y),
      .req_dir_i      (req_dir),
      .req_step_i     (req_step),
      .resp_valid_o   (resp_valid),
      .resp_ready_i   (resp_ready),
      .resp_allowed_o (resp_allowed),
      .resp_x_o       (resp_x),
      .resp_y_o       (resp_y),
      .blocked_cnt_o  (blocked_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Issue one request; when push is set, record the hand-computed response.
   task automatic issue(input logic [10:0] x, input logic [10:0] y, input logic [1:0] d,
                        input logic [3:0] s, input logic allowed, input logic [10:0] ex,
                        input logic [10:0] ey, input bit push);
      int   n;
      exp_t e;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_wait", req_ready, 1);
      req_x     = x;
      req_y     = y;
      req_dir   = d;
      req_step  = s;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      if (push) begin
         if (!allowed && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
         e.allowed = allowed;
         e.x       = ex;
         e.y       = ey;
         e.cnt     = exp_cnt;
         e.t_acc   = cyc;
         exp_q.push_back(e);
      end
   endtask

   // Monitor: pop on each new response, then hold it against every valid cycle.
   always @(negedge clk) begin
      if (!resetN) begin
         in_resp = 0;
      end else if (!resp_valid) begin
         in_resp = 0;
      end else begin
         if (!in_resp) begin
            chk("resp_expected", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
               cur     = exp_q.pop_front();
               in_resp = 1;
               chk("latency", cyc - cur.t_acc, 4);
            end
         end
         if (in_resp) begin
            chk("resp_allowed", resp_allowed, cur.allowed);
            chk("resp_x", resp_x, cur.x);
            chk("resp_y", resp_y, cur.y);
            chk("blocked_cnt", blocked_cnt, cur.cnt);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
      $fatal(1);
   end

   initial begin
      int n;
      resetN     = 1'b0;
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      req_x      = '0;
      req_y      = '0;
      req_dir    = '0;
      req_step   = '0;
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_allowed", resp_allowed, 0);
      chk("rst_resp_x", resp_x, 0);
      chk("rst_resp_y", resp_y, 0);
      chk("rst_blocked_cnt", blocked_cnt, 0);

      // Open move along the top corridor, then four moves into the top edge.
      issue(96, 16, R, 4, 1, 100, 16, 1);
      repeat (4) issue(96, 16, U, 1, 0, 96, 16, 1);

      // Tunnel wrap in both directions.
      issue(524, 208, R, 8, 1, 68, 208, 1);
      issue(68, 208, L, 8, 1, 524, 208, 1);

      // Backpressure with a zero-step query; extra requests must be ignored.
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      resp_ready = 1'b0;
      issue(96, 16, R, 0, 1, 96, 16, 1);
      n = 0;
      while (!resp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("bp_valid_seen", resp_valid, 1);
      for (int i = 0; i < 3; i++) begin
         req_x     = 11'd300;
         req_y     = 11'd300;
         req_dir   = D;
         req_step  = 4'd9;
         req_valid = 1'b1;
         @(negedge clk);
         chk("bp_req_ready_low", req_ready, 0);
         chk("bp_valid_held", resp_valid, 1);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_req_ready_after", req_ready, 1);
      chk("bp_valid_cleared", resp_valid, 0);
      chk("bp_x_kept", resp_x, 96);

      // Reset while the query sits in CHK0.
      issue(96, 16, U, 1, 0, 96, 16, 0);
      @(negedge clk);
      resetN = 1'b0;
      #1;
      chk("midrst_req_ready", req_ready, 1);
      chk("midrst_resp_valid", resp_valid, 0);
      chk("midrst_allowed", resp_allowed, 0);
      chk("midrst_x", resp_x, 0);
      chk("midrst_y", resp_y, 0);
      chk("midrst_cnt", blocked_cnt, 0);
      exp_cnt = 16'd0;
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
      chk("midrst_ready_after", req_ready, 1);
      repeat (8) @(negedge clk);
      chk("midrst_no_resp", resp_valid, 0);

      // Corner straddle, negative coordinates, maze side wall, bottom wall.
      issue(100, 16, D, 2, 0, 100, 16, 1);
      issue(2, 208, L, 5, 1, 461, 208, 1);
      issue(96, 0, U, 5, 0, 96, 0, 1);
      issue(96, 16, L, 5, 0, 96, 16, 1);
      issue(96, 432, D, 2, 0, 96, 432, 1);

      n = 0;
      while ((exp_q.size() != 0 || in_resp || !req_ready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain", exp_q.size(), 0);
      chk("final_cnt", blocked_cnt, 4);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/wall_collision_checker.md
Name: wall_collision_checker

Overview:
- Query engine for walls_pkg::wall_mask: a movement controller asks "may this sprite move `step` pixels in direction `dir`?"; the block returns allowed/blocked and the resulting position.
- Sits between the Pac-Man/ghost movement FSMs and the static maze mask.
- One request in flight; valid/ready handshake on both request and response.
- Handles tunnel wrap-around and keeps a saturating blocked-move counter.

Parameters:
- TILE_PX, 16, tile and sprite edge in pixels (640/TILE_WIDTH); the sprite is TILE_PX x TILE_PX, position is its top-left corner.
- POS_W, 11, pixel-coordinate width.
- WRAP_LO, 64, leftmost legal x; equals START_X*TILE_PX-TILE_PX.
- WRAP_HI, 528, rightmost legal x; equals (END_X+1)*TILE_PX.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle, request accepted when both high.
- req_x  in  POS_W  current sprite x, in pixels.
- req_y  in  POS_W  current sprite y, in pixels.
- req_dir  in  2  0=RIGHT, 1=LEFT, 2=UP, 3=DOWN.
- req_step  in  4  move distance in pixels, 0..15.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_allowed  out  1  1 = move legal.
- resp_x  out  POS_W  resulting x.
- resp_y  out  POS_W  resulting y.
- blocked_cnt  out  16  count of blocked responses, saturating.

Behaviour:
- Reset (async, resetN=0) sets: state IDLE; req_ready=1; resp_valid=0; resp_allowed=0; resp_x=0; resp_y=0; blocked_cnt=0.
- FSM states: IDLE -> CALC -> CHK0 -> CHK1 -> RESP -> IDLE.
- IDLE: req_ready=1. On req_valid, capture x, y, dir and step, then go to CALC. req_ready=0 in every other state.
- CALC: compute the next position (nx, ny) in 12-bit signed arithmetic, plus two leading-edge corner pixels, with E = TILE_PX-1:
  - RIGHT: nx=x+step; corners (nx+E, y) and (nx+E, y+E).
  - LEFT: nx=x-step; corners (nx, y) and (nx, y+E).
  - UP: ny=y-step; corners (x, ny) and (x+E, ny).
  - DOWN: ny=y+step; corners (x, ny+E) and (x+E, ny+E).
  - Unchanged axis copies the request value.
- Tile index: col = px >> 4, row = py >> 4. Negative px or py is out of range.
- Lookup rules, in order:
  - row outside START_Y..END_Y (including negative) -> wall.
  - else col outside START_X..END_X (including negative) -> empty (tunnel).
  - else the value of wall_mask[row][col].
- CHK0: look up corner A and register the result. CHK1: look up corner B and register the result.
- RESP entry (registered in the CHK1 -> RESP transition):
  - resp_allowed = !wallA && !wallB.
  - If allowed, resp_x/resp_y = next position after wrap; otherwise the captured request position.
  - If blocked, blocked_cnt increments, saturating at 16'hFFFF.
- Wrap (applied only when allowed): RIGHT with nx > WRAP_HI -> nx-464; LEFT with nx < WRAP_LO -> nx+464. No vertical wrap.
- Latency: request accepted on edge T; resp_valid high from edge T+4.
- resp_valid, resp_allowed, resp_x, resp_y and blocked_cnt are all registered and stay stable while resp_valid=1 && resp_ready=0.
- On resp_valid && resp_ready: clear resp_valid and return to IDLE. A new request is acceptable on the following cycle; no response/request overlap.
- resp_x, resp_y and resp_allowed keep their last values after the handshake.
- step=0 is a legal request and checks the current footprint.
- req_valid deasserting after acceptance has no effect on the in-flight query.
- Reset mid-query (any state) discards the query: no response, outputs return to reset values.

Test Plan:
- Reset, then req (x=96, y=16, RIGHT, step=4): corners hit col 7, row 1 (empty) -> resp_valid at T+4, allowed=1, resp=(100,16), blocked_cnt=0.
- req (96, 16, UP, 1): ny=15 gives row 0 (wall) -> allowed=0, resp=(96,16), blocked_cnt=1. Repeat 3x -> blocked_cnt=4.
- Tunnel: req (524, 208, RIGHT, 8): nx=532, corner col 34 is outside the maze, row 13 -> empty -> allowed=1, wrapped resp=(68,208). Then req (68, 208, LEFT, 8): nx=60 -> resp=(524,208).
- Backpressure: hold resp_ready=0 for 3 cycles after resp_valid -> resp_* stable, req_ready=0, extra req_valid ignored. resp_ready=1 -> next-cycle req_ready=1.
- Reset mid-operation: drop resetN during CHK0 -> resp_valid never asserts, blocked_cnt=0, req_ready=1 after release.
- Corner straddle: req (100, 16, DOWN, 2): corners (100,33) tile (2,6) is empty and (115,33) tile (2,7) is a wall -> allowed=0, resp=(100,16).
